key_scan_encoder: RTL and testbench

KEY_SCAN_ENCODER -- requirements
Module: key_scan_encoder

---
 rtl/key_scan_encoder_if.sv | 21 ++
 rtl/key_scan_encoder.sv | 117 +++++++++++
 tb/tb_key_scan_encoder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_scan_encoder_if.sv
// Signal bundle between the key-scan encoder and its surroundings: raw key and
// octave inputs in, debounced keys, encoded note and octave out.
interface key_scan_encoder_if;
   logic [11:0] keys_raw;
   logic [3:0]  octave_raw;
   logic [11:0] keys_db;
   logic [3:0]  note;
   logic        note_valid;
   logic [3:0]  octave;
   logic        note_change;

   modport master (
      output keys_raw, octave_raw,
      input  keys_db, note, note_valid, octave, note_change
   );

   modport slave (
      input  keys_raw, octave_raw,
      output keys_db, note, note_valid, octave, note_change
   );
endinterface

// File: rtl/key_scan_encoder.sv
// 12-key piano scanner: synchronise, debounce, priority-encode the highest note.
// Define KEY_SCAN_DEBOUNCE_EN to build in the tick prescaler and per-key debounce counters.
module key_scan_encoder #(
   parameter int TICK_DIV       = 1000,
   parameter int DEBOUNCE_TICKS = 5
) (
   input logic               clk,
   input logic               rst,
   key_scan_encoder_if.slave bus
);
   logic [11:0] keys_meta_reg;
   logic [11:0] keys_sync_reg;
   logic [3:0]  oct_meta_reg;
   logic [3:0]  oct_sync_reg;
   logic [11:0] db_bits;

   // The octave clamp is folded into the second synchroniser stage to keep 2-cycle latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         keys_meta_reg <= '0;
         keys_sync_reg <= '0;
         oct_meta_reg  <= '0;
         oct_sync_reg  <= '0;
      end else begin
         keys_meta_reg <= bus.keys_raw;
         keys_sync_reg <= keys_meta_reg;
         oct_meta_reg  <= bus.octave_raw;
         oct_sync_reg  <= (oct_meta_reg > 4'd8) ? 4'd8 : oct_meta_reg;
      end
   end

`ifdef KEY_SCAN_DEBOUNCE_EN
   localparam int PRE_W = $clog2(TICK_DIV);
   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic [PRE_W-1:0] pre_reg;
   logic             tick;

   // Tick is taken on the same edge the prescaler wraps, so the first one lands TICK_DIV cycles after reset.
   assign tick = (pre_reg == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_reg <= '0;
      end else if (tick) begin
         pre_reg <= '0;
      end else begin
         pre_reg <= pre_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < 12; gi++) begin : g_key
         logic [CNT_W-1:0] cnt_reg;
         logic             db_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
               db_reg  <= 1'b0;
            end else if (keys_sync_reg[gi] == db_reg) begin
               cnt_reg <= '0;
            end else if (tick) begin
               if (cnt_reg == CNT_LAST) begin
                  db_reg  <= keys_sync_reg[gi];
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         assign db_bits[gi] = db_reg;
      end
   endgenerate
`else
   assign db_bits = keys_sync_reg;
`endif

   logic [3:0] note_reg;
   logic [3:0] note_next;
   logic       note_valid_reg;
   logic [4:0] prev_reg;
   logic       change_reg;

   // Ascending scan so the highest set bit wins; with no key down the old note is held.
   always_comb begin
      note_next = note_reg;
      for (int i = 0; i < 12; i++) begin
         if (db_bits[i]) begin
            note_next = 4'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         note_reg       <= '0;
         note_valid_reg <= 1'b0;
         prev_reg       <= '0;
         change_reg     <= 1'b0;
      end else begin
         note_reg       <= note_next;
         note_valid_reg <= |db_bits;
         prev_reg       <= {note_valid_reg, note_reg};
         change_reg     <= ({note_valid_reg, note_reg} != prev_reg);
      end
   end

   assign bus.keys_db     = db_bits;
   assign bus.note        = note_reg;
   assign bus.note_valid  = note_valid_reg;
   assign bus.octave      = oct_sync_reg;
   assign bus.note_change = change_reg;
endmodule

// File: tb/tb_key_scan_encoder.sv
// Scoreboard bench for key_scan_encoder (TICK_DIV=4, DEBOUNCE_TICKS=3); expectations
// adapt to whether KEY_SCAN_DEBOUNCE_EN is defined.
module tb_key_scan_encoder;
`ifdef KEY_SCAN_DEBOUNCE_EN
   localparam int DB_LO = 10;
   localparam int DB_HI = 14;
`else
   localparam int DB_LO = 2;
   localparam int DB_HI = 2;
`endif

   typedef struct {
      logic [11:0] val;
      int          lo;
      int          hi;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   exp_t q_db[$];
   exp_t q_note[$];
   exp_t q_pulse[$];
   exp_t q_oct[$];

   logic [11:0] last_db;
   logic [4:0]  last_note;
   logic [3:0]  last_oct;

   key_scan_encoder_if bus ();

   key_scan_encoder #(
      .TICK_DIV       (4),
      .DEBOUNCE_TICKS (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic cmp_ev(input string name, input exp_t e, input logic [11:0] act, input bit found);
      vec_cnt++;
      if (!found) begin
         err_cnt++;
         $display("FAIL %s: got change to %h at cycle %0d, required no change", name, act, cyc);
      end else if (e.val !== act || cyc < e.lo || cyc > e.hi) begin
         err_cnt++;
         $display("FAIL %s: got %h at cycle %0d, required %h in cycles %0d..%0d",
                  name, act, cyc, e.val, e.lo, e.hi);
      end else begin
         $display("ok   %s: %h at cycle %0d", name, act, cyc);
      end
   endtask

   task automatic timeout(input string name, input exp_t e);
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s: got no change by cycle %0d, required %h by cycle %0d", name, cyc, e.val, e.hi);
   endtask

   // Monitor: one sample per cycle, 1 time unit after the rising edge.
   always begin
      exp_t none;
      none.val = '0;
      none.lo  = 0;
      none.hi  = 0;
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (rst) begin
         last_db   = bus.keys_db;
         last_note = {bus.note_valid, bus.note};
         last_oct  = bus.octave;
      end else begin
         if (bus.keys_db !== last_db) begin
            if (q_db.size() > 0) cmp_ev("keys_db", q_db.pop_front(), bus.keys_db, 1'b1);
            else cmp_ev("keys_db", none, bus.keys_db, 1'b0);
            last_db = bus.keys_db;
         end
         if ({bus.note_valid, bus.note} !== last_note) begin
            if (q_note.size() > 0) cmp_ev("note", q_note.pop_front(), 12'({bus.note_valid, bus.note}), 1'b1);
            else cmp_ev("note", none, 12'({bus.note_valid, bus.note}), 1'b0);
            last_note = {bus.note_valid, bus.note};
         end
         if (bus.octave !== last_oct) begin
            if (q_oct.size() > 0) cmp_ev("octave", q_oct.pop_front(), 12'(bus.octave), 1'b1);
            else cmp_ev("octave", none, 12'(bus.octave), 1'b0);
            last_oct = bus.octave;
         end
         if (bus.note_change !== 1'b0) begin
            if (q_pulse.size() > 0) cmp_ev("note_change", q_pulse.pop_front(), 12'(bus.note_change), 1'b1);
            else cmp_ev("note_change", none, 12'(bus.note_change), 1'b0);
         end
         if (q_db.size() > 0 && cyc > q_db[0].hi) timeout("keys_db", q_db.pop_front());
         if (q_note.size() > 0 && cyc > q_note[0].hi) timeout("note", q_note.pop_front());
         if (q_oct.size() > 0 && cyc > q_oct[0].hi) timeout("octave", q_oct.pop_front());
         if (q_pulse.size() > 0 && cyc > q_pulse[0].hi) timeout("note_change", q_pulse.pop_front());
      end
   end

   // Called on the falling edge where the key level becomes stable at the DUT input.
   task automatic push_keys(input logic [11:0] v, input logic [4:0] nv_note, input bit note_moves);
      exp_t e;
      e.val = v;
      e.lo  = cyc + DB_LO;
      e.hi  = cyc + DB_HI;
      q_db.push_back(e);
      if (note_moves) begin
         e.val = 12'(nv_note);
         e.lo  = e.lo + 1;
         e.hi  = e.hi + 1;
         q_note.push_back(e);
         e.val = 12'd1;
         e.lo  = e.lo + 1;
         e.hi  = e.hi + 1;
         q_pulse.push_back(e);
      end
   endtask

   task automatic push_oct(input logic [3:0] v);
      exp_t e;
      e.val = 12'(v);
      e.lo  = cyc + 2;
      e.hi  = cyc + 2;
      q_oct.push_back(e);
   endtask

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
      vec_cnt++;
      if (act !== req) begin
         err_cnt++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.keys_raw   = 12'h000;
      bus.octave_raw = 4'd0;
      rst = 1'b1;
      idle(3);
      chk("reset keys_db", bus.keys_db, 12'h000);
      chk("reset note", 12'(bus.note), 12'h0);
      chk("reset note_valid", 12'(bus.note_valid), 12'h0);
      chk("reset octave", 12'(bus.octave), 12'h0);
      chk("reset note_change", 12'(bus.note_change), 12'h0);
      rst = 1'b0;

      // Idle with no keys: any output movement is an unexpected event.
      idle(100);
      chk("idle keys_db", bus.keys_db, 12'h000);

      bus.keys_raw = 12'h010;
      push_keys(12'h010, {1'b1, 4'd4}, 1'b1);
      idle(30);

      // Three-cycle low glitch on bit 4.
      bus.keys_raw = 12'h000;
`ifndef KEY_SCAN_DEBOUNCE_EN
      push_keys(12'h000, {1'b0, 4'd4}, 1'b1);
`endif
      idle(3);
      bus.keys_raw = 12'h010;
`ifndef KEY_SCAN_DEBOUNCE_EN
      push_keys(12'h010, {1'b1, 4'd4}, 1'b1);
`endif
      idle(30);
      chk("post-glitch note", 12'(bus.note), 12'h4);

      bus.keys_raw = 12'hA10;
      push_keys(12'hA10, {1'b1, 4'd11}, 1'b1);
      idle(30);

      bus.keys_raw = 12'h000;
      push_keys(12'h000, {1'b0, 4'd11}, 1'b1);
      idle(30);
      chk("released note held", 12'(bus.note), 12'hB);

      bus.octave_raw = 4'd5;
      push_oct(4'd5);
      idle(5);
      bus.octave_raw = 4'd12;
      push_oct(4'd8);
      idle(5);

      // Reset in the middle of a debounce count.
      bus.keys_raw = 12'h001;
`ifndef KEY_SCAN_DEBOUNCE_EN
      push_keys(12'h001, {1'b1, 4'd0}, 1'b1);
`endif
      idle(6);
      rst = 1'b1;
      idle(1);
      chk("mid reset keys_db", bus.keys_db, 12'h000);
      chk("mid reset note", 12'(bus.note), 12'h0);
      chk("mid reset octave", 12'(bus.octave), 12'h0);
      rst = 1'b0;
      push_keys(12'h001, {1'b1, 4'd0}, 1'b1);
      push_oct(4'd8);
      idle(30);

      bus.octave_raw = 4'd0;
      push_oct(4'd0);
      idle(20);

      foreach (q_db[i]) timeout("keys_db", q_db[i]);
      foreach (q_note[i]) timeout("note", q_note[i]);
      foreach (q_oct[i]) timeout("octave", q_oct[i]);
      foreach (q_pulse[i]) timeout("note_change", q_pulse[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
